// File: rtl/vc_input_unit.sv
// Router input unit: per-VC flit FIFOs behind a packet-framing write filter, a
// per-VC IDLE/VA/ACTIVE packet FSM with XY routing, and a registered output flit.
module vc_input_unit #(
  parameter int VC_NUM           = 2,
  parameter int VC_SIZE          = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  parameter int BUFFER_SIZE      = 8,
  parameter int ON_OFF_THRESHOLD = 2,
  parameter int MESH_SIZE_X      = 4,
  parameter int MESH_SIZE_Y      = 4,
  parameter int DEST_X_W         = (MESH_SIZE_X > 1) ? $clog2(MESH_SIZE_X) : 1,
  parameter int DEST_Y_W         = (MESH_SIZE_Y > 1) ? $clog2(MESH_SIZE_Y) : 1,
  parameter int X_CURRENT        = MESH_SIZE_X / 2,
  parameter int Y_CURRENT        = MESH_SIZE_Y / 2,
  parameter int PAYLOAD_W        = 16,
  parameter int DROP_CNT_W       = 8,
  parameter int PORT_W           = 3,
  parameter int FLIT_W           = 2 + VC_SIZE + DEST_X_W + DEST_Y_W + PAYLOAD_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [FLIT_W-1:0]        data_i,
  input  logic                     valid_flit_i,
  input  logic [VC_NUM*VC_SIZE-1:0] vc_new_i,
  input  logic [VC_NUM-1:0]        vc_valid_i,
  input  logic [VC_SIZE-1:0]       vc_sel_i,
  input  logic                     valid_sel_i,
  output logic [FLIT_W-1:0]        flit_o,
  output logic                     valid_flit_o,
  output logic [VC_NUM-1:0]        on_off_o,
  output logic [VC_NUM-1:0]        vc_request_o,
  output logic [VC_NUM*PORT_W-1:0] out_port_o,
  output logic [VC_NUM-1:0]        vc_allocatable_o,
  output logic [VC_NUM-1:0]        is_full_o,
  output logic [VC_NUM-1:0]        is_empty_o,
  output logic [DROP_CNT_W-1:0]    drop_cnt_o,
  output logic [VC_NUM*2-1:0]      vc_state_o
);

  // Flit layout, MSB first: label[1:0] | vc_id | x_dest | y_dest | payload.
  localparam int Y_LSB   = PAYLOAD_W;
  localparam int X_LSB   = Y_LSB + DEST_Y_W;
  localparam int VC_LSB  = X_LSB + DEST_X_W;
  localparam int LBL_LSB = VC_LSB + VC_SIZE;
  localparam int PTR_W   = $clog2(BUFFER_SIZE);
  localparam int CNT_W   = PTR_W + 1;

  localparam logic [1:0] LBL_HEAD     = 2'b00;
  localparam logic [1:0] LBL_BODY     = 2'b01;
  localparam logic [1:0] LBL_TAIL     = 2'b10;
  localparam logic [1:0] LBL_HEADTAIL = 2'b11;

  localparam logic [PORT_W-1:0] PORT_LOCAL = 3'd0;
  localparam logic [PORT_W-1:0] PORT_NORTH = 3'd1;
  localparam logic [PORT_W-1:0] PORT_SOUTH = 3'd2;
  localparam logic [PORT_W-1:0] PORT_WEST  = 3'd3;
  localparam logic [PORT_W-1:0] PORT_EAST  = 3'd4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_VA     = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  localparam logic [DEST_X_W-1:0] X_CUR    = DEST_X_W'(X_CURRENT);
  localparam logic [DEST_Y_W-1:0] Y_CUR    = DEST_Y_W'(Y_CURRENT);
  localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(BUFFER_SIZE);

  // Handshakes: vc_request_o[v] is held for as long as VC v sits in VA and a
  // vc_valid_i[v] strobe only takes effect there; a valid_sel_i/vc_sel_i read
  // strobe pops only when the selected VC is ACTIVE and non-empty.

  logic [FLIT_W-1:0]   mem_q      [VC_NUM][BUFFER_SIZE];
  logic [PTR_W-1:0]    wr_ptr_q   [VC_NUM];
  logic [PTR_W-1:0]    wr_ptr_d   [VC_NUM];
  logic [PTR_W-1:0]    rd_ptr_q   [VC_NUM];
  logic [PTR_W-1:0]    rd_ptr_d   [VC_NUM];
  logic [CNT_W-1:0]    cnt_q      [VC_NUM];
  logic [CNT_W-1:0]    cnt_d      [VC_NUM];
  logic [1:0]          state_q    [VC_NUM];
  logic [1:0]          state_d    [VC_NUM];
  logic [PORT_W-1:0]   out_port_q [VC_NUM];
  logic [PORT_W-1:0]   out_port_d [VC_NUM];
  logic [VC_SIZE-1:0]  vc_new_q   [VC_NUM];
  logic [VC_SIZE-1:0]  vc_new_d   [VC_NUM];
  logic [FLIT_W-1:0]   front      [VC_NUM];
  logic [VC_NUM-1:0]   in_pkt_q, in_pkt_d;
  logic [VC_NUM-1:0]   on_off_q, on_off_d;
  logic [VC_NUM-1:0]   framing_ok, wr_en, pop;
  logic [FLIT_W-1:0]   flit_o_q, flit_o_d;
  logic                valid_flit_o_q, valid_flit_o_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [VC_SIZE-1:0]  wr_vc;
  logic [1:0]          wr_label;

  function automatic logic [PORT_W-1:0] xy_route(input logic [FLIT_W-1:0] f);
    logic [DEST_X_W-1:0] xd;
    logic [DEST_Y_W-1:0] yd;
    xd = f[X_LSB +: DEST_X_W];
    yd = f[Y_LSB +: DEST_Y_W];
    if (xd > X_CUR)      xy_route = PORT_EAST;
    else if (xd < X_CUR) xy_route = PORT_WEST;
    else if (yd > Y_CUR) xy_route = PORT_SOUTH;
    else if (yd < Y_CUR) xy_route = PORT_NORTH;
    else                 xy_route = PORT_LOCAL;
  endfunction

  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      front[v] = mem_q[v][rd_ptr_q[v]];
    end
  end

  always_comb begin
    wr_vc          = data_i[VC_LSB +: VC_SIZE];
    wr_label       = data_i[LBL_LSB +: 2];
    flit_o_d       = flit_o_q;
    valid_flit_o_d = 1'b0;
    drop_cnt_d     = drop_cnt_q;
    in_pkt_d       = in_pkt_q;
    on_off_d       = on_off_q;
    framing_ok     = '0;
    wr_en          = '0;
    pop            = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      wr_ptr_d[v]   = wr_ptr_q[v];
      rd_ptr_d[v]   = rd_ptr_q[v];
      cnt_d[v]      = cnt_q[v];
      state_d[v]    = state_q[v];
      out_port_d[v] = out_port_q[v];
      vc_new_d[v]   = vc_new_q[v];

      pop[v] = valid_sel_i && (vc_sel_i == VC_SIZE'(v)) &&
               (state_q[v] == ST_ACTIVE) && (cnt_q[v] != '0);

      // Packet framing: heads only between packets, body/tail only inside one.
      framing_ok[v] = in_pkt_q[v] ? ((wr_label == LBL_BODY) || (wr_label == LBL_TAIL))
                                  : ((wr_label == LBL_HEAD) || (wr_label == LBL_HEADTAIL));
      wr_en[v] = valid_flit_i && (wr_vc == VC_SIZE'(v)) && framing_ok[v] &&
                 ((cnt_q[v] != FULL_CNT) || pop[v]);

      if (wr_en[v]) begin
        wr_ptr_d[v] = wr_ptr_q[v] + PTR_W'(1);
        if (wr_label == LBL_HEAD)      in_pkt_d[v] = 1'b1;
        else if (wr_label == LBL_TAIL) in_pkt_d[v] = 1'b0;
      end
      if (pop[v]) rd_ptr_d[v] = rd_ptr_q[v] + PTR_W'(1);
      case ({wr_en[v], pop[v]})
        2'b10:   cnt_d[v] = cnt_q[v] + CNT_W'(1);
        2'b01:   cnt_d[v] = cnt_q[v] - CNT_W'(1);
        default: cnt_d[v] = cnt_q[v];
      endcase

      case (state_q[v])
        ST_IDLE: begin
          if ((cnt_q[v] != '0) && ((front[v][LBL_LSB +: 2] == LBL_HEAD) ||
                                   (front[v][LBL_LSB +: 2] == LBL_HEADTAIL))) begin
            state_d[v]    = ST_VA;
            out_port_d[v] = xy_route(front[v]);
          end
        end
        ST_VA: begin
          if (vc_valid_i[v]) begin
            state_d[v]  = ST_ACTIVE;
            vc_new_d[v] = vc_new_i[v*VC_SIZE +: VC_SIZE];
          end
        end
        ST_ACTIVE: begin
          if (pop[v]) begin
            flit_o_d                      = front[v];
            flit_o_d[VC_LSB +: VC_SIZE]   = vc_new_q[v];
            valid_flit_o_d                = 1'b1;
            if ((front[v][LBL_LSB +: 2] == LBL_TAIL) ||
                (front[v][LBL_LSB +: 2] == LBL_HEADTAIL)) begin
              state_d[v] = ST_IDLE;
            end
          end
        end
        default: state_d[v] = ST_IDLE;
      endcase

      on_off_d[v] = (BUFFER_SIZE - int'(cnt_d[v])) > ON_OFF_THRESHOLD;
    end
    // A flit that reaches no FIFO was discarded by framing, fullness or VC id.
    if (valid_flit_i && (wr_en == '0) && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < VC_NUM; v++) begin
        wr_ptr_q[v]   <= '0;
        rd_ptr_q[v]   <= '0;
        cnt_q[v]      <= '0;
        state_q[v]    <= ST_IDLE;
        out_port_q[v] <= PORT_LOCAL;
        vc_new_q[v]   <= '0;
      end
      in_pkt_q       <= '0;
      on_off_q       <= '1;
      flit_o_q       <= '0;
      valid_flit_o_q <= 1'b0;
      drop_cnt_q     <= '0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        wr_ptr_q[v]   <= wr_ptr_d[v];
        rd_ptr_q[v]   <= rd_ptr_d[v];
        cnt_q[v]      <= cnt_d[v];
        state_q[v]    <= state_d[v];
        out_port_q[v] <= out_port_d[v];
        vc_new_q[v]   <= vc_new_d[v];
      end
      in_pkt_q       <= in_pkt_d;
      on_off_q       <= on_off_d;
      flit_o_q       <= flit_o_d;
      valid_flit_o_q <= valid_flit_o_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  // Storage carries no reset; occupancy is tracked solely by the pointers.
  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_NUM; v++) begin
      if (wr_en[v]) mem_q[v][wr_ptr_q[v]] <= data_i;
    end
  end

  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      vc_request_o[v]                  = (state_q[v] == ST_VA);
      out_port_o[v*PORT_W +: PORT_W]   = out_port_q[v];
      is_empty_o[v]                    = (cnt_q[v] == '0);
      is_full_o[v]                     = (cnt_q[v] == FULL_CNT);
      vc_allocatable_o[v]              = (state_q[v] == ST_IDLE) && (cnt_q[v] == '0);
      vc_state_o[v*2 +: 2]             = state_q[v];
    end
  end

  assign flit_o       = flit_o_q;
  assign valid_flit_o = valid_flit_o_q;
  assign on_off_o     = on_off_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_vc_input_unit.sv
// Scenario bench for vc_input_unit: per-VC reference FIFOs feed an expected
// output queue when reads are issued; a negedge monitor compares flit_o.
module tb_vc_input_unit;

  localparam int FLIT_W  = 23;
  localparam int VC_SIZE = 1;
  localparam int VC_LSB  = 20;
  localparam logic [1:0] H = 2'b00, B = 2'b01, T = 2'b10, HT = 2'b11;
  localparam logic [2:0] P_L = 3'd0, P_N = 3'd1, P_S = 3'd2, P_W = 3'd3, P_E = 3'd4;
  localparam logic [1:0] S_IDLE = 2'd0;

  logic              clk, rst_n;
  logic [FLIT_W-1:0] data_i;
  logic              valid_flit_i;
  logic [1:0]        vc_new_i, vc_valid_i;
  logic [0:0]        vc_sel_i;
  logic              valid_sel_i;
  logic [FLIT_W-1:0] flit_o;
  logic              valid_flit_o;
  logic [1:0]        on_off_o, vc_request_o, vc_allocatable_o, is_full_o, is_empty_o;
  logic [5:0]        out_port_o;
  logic [7:0]        drop_cnt_o;
  logic [3:0]        vc_state_o;

  int checks = 0;
  int passes = 0;
  logic [7:0] exp_drops = '0;
  logic [FLIT_W-1:0] exp_q[$];
  logic [FLIT_W-1:0] mq0[$];
  logic [FLIT_W-1:0] mq1[$];
  logic [VC_SIZE-1:0] newvc_model [2];

  vc_input_unit dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_flit_i(valid_flit_i),
    .vc_new_i(vc_new_i), .vc_valid_i(vc_valid_i), .vc_sel_i(vc_sel_i),
    .valid_sel_i(valid_sel_i), .flit_o(flit_o), .valid_flit_o(valid_flit_o),
    .on_off_o(on_off_o), .vc_request_o(vc_request_o), .out_port_o(out_port_o),
    .vc_allocatable_o(vc_allocatable_o), .is_full_o(is_full_o),
    .is_empty_o(is_empty_o), .drop_cnt_o(drop_cnt_o), .vc_state_o(vc_state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Output monitor: every valid output flit must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && valid_flit_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_flit: got %h, expected no output", flit_o);
      end else begin
        logic [FLIT_W-1:0] e;
        e = exp_q.pop_front();
        if (flit_o !== e) $display("FAIL flit_o: got %h, expected %h", flit_o, e);
        else passes++;
      end
    end
  end

  function automatic logic [FLIT_W-1:0] mk(input logic [1:0] lbl, input logic vc,
                                           input logic [1:0] x, input logic [1:0] y,
                                           input logic [15:0] p);
    return {lbl, vc, x, y, p};
  endfunction

  // Drivers
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_cycle(input logic wr, input logic [FLIT_W-1:0] f, input logic wr_ok,
                          input logic rd, input int rv, input logic rd_ok);
    logic [FLIT_W-1:0] e;
    valid_flit_i = wr;
    data_i       = f;
    valid_sel_i  = rd;
    vc_sel_i     = VC_SIZE'(rv);
    if (rd && rd_ok) begin
      checks++;
      if ((rv == 0 && mq0.size() == 0) || (rv == 1 && mq1.size() == 0)) begin
        $display("FAIL model_underflow: read on vc %0d with nothing expected stored", rv);
      end else begin
        passes++;
        e = (rv == 0) ? mq0.pop_front() : mq1.pop_front();
        e[VC_LSB +: VC_SIZE] = newvc_model[rv];
        exp_q.push_back(e);
      end
    end
    if (wr && wr_ok) begin
      if (f[VC_LSB +: VC_SIZE] == 1'b0) mq0.push_back(f);
      else mq1.push_back(f);
    end
    if (wr && !wr_ok) exp_drops++;
    @(negedge clk);
    valid_flit_i = 1'b0;
    valid_sel_i  = 1'b0;
  endtask

  task automatic write_flit(input logic [FLIT_W-1:0] f, input logic ok);
    do_cycle(1'b1, f, ok, 1'b0, 0, 1'b0);
  endtask

  task automatic read_vc(input int v, input logic ok);
    do_cycle(1'b0, '0, 1'b0, 1'b1, v, ok);
  endtask

  task automatic grant(input int v, input logic nv);
    vc_valid_i[v]   = 1'b1;
    vc_new_i[v]     = nv;
    newvc_model[v]  = nv;
    @(negedge clk);
    vc_valid_i = '0;
  endtask

  task automatic check_drained(input string name);
    step();
    checks++;
    if (exp_q.size() != 0 || mq0.size() != 0 || mq1.size() != 0)
      $display("FAIL %s_drained: pending exp=%0d vc0=%0d vc1=%0d, required 0/0/0",
               name, exp_q.size(), mq0.size(), mq1.size());
    else passes++;
    checks++;
    if (drop_cnt_o !== exp_drops) $display("FAIL %s_drops: got %0d, required %0d", name, drop_cnt_o, exp_drops);
    else passes++;
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0; data_i = '0; valid_flit_i = 0; vc_new_i = '0; vc_valid_i = '0;
    vc_sel_i = '0; valid_sel_i = 0;
    step(); step();
    checks++; if (valid_flit_o !== 1'b0) $display("FAIL rst_valid: got %b, required 0", valid_flit_o); else passes++;
    checks++; if (flit_o !== '0) $display("FAIL rst_flit: got %h, required 0", flit_o); else passes++;
    checks++; if (vc_request_o !== 2'b00) $display("FAIL rst_req: got %b, required 00", vc_request_o); else passes++;
    checks++; if (out_port_o !== {P_L, P_L}) $display("FAIL rst_port: got %h, required 0", out_port_o); else passes++;
    checks++; if (on_off_o !== 2'b11) $display("FAIL rst_on_off: got %b, required 11", on_off_o); else passes++;
    checks++; if (vc_allocatable_o !== 2'b11) $display("FAIL rst_alloc: got %b, required 11", vc_allocatable_o); else passes++;
    checks++; if (is_empty_o !== 2'b11) $display("FAIL rst_empty: got %b, required 11", is_empty_o); else passes++;
    checks++; if (is_full_o !== 2'b00) $display("FAIL rst_full: got %b, required 00", is_full_o); else passes++;
    checks++; if (drop_cnt_o !== 8'd0) $display("FAIL rst_drop: got %0d, required 0", drop_cnt_o); else passes++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_packet();
    write_flit(mk(H, 1'b1, 2'd3, 2'd0, 16'hA001), 1'b1);
    checks++; if (vc_request_o[1] !== 1'b0) $display("FAIL basic_req_early: got %b, required 0", vc_request_o[1]); else passes++;
    step();
    checks++; if (vc_request_o[1] !== 1'b1) $display("FAIL basic_req_head1: got %b, required 1", vc_request_o[1]); else passes++;
    checks++; if (out_port_o[5:3] !== P_E) $display("FAIL basic_port: got %0d, required %0d", out_port_o[5:3], P_E); else passes++;
    write_flit(mk(B, 1'b1, 2'd0, 2'd0, 16'hA002), 1'b1);
    write_flit(mk(B, 1'b1, 2'd0, 2'd0, 16'hA003), 1'b1);
    write_flit(mk(T, 1'b1, 2'd0, 2'd0, 16'hA004), 1'b1);
    checks++; if (vc_request_o[1] !== 1'b1) $display("FAIL basic_req_hold: got %b, required 1", vc_request_o[1]); else passes++;
    grant(1, 1'b0);
    checks++; if (vc_request_o[1] !== 1'b0) $display("FAIL basic_req_drop: got %b, required 0", vc_request_o[1]); else passes++;
    for (int i = 0; i < 4; i++) read_vc(1, 1'b1);
    step();
    checks++; if (vc_state_o[3:2] !== S_IDLE) $display("FAIL basic_state: got %0d, required 0", vc_state_o[3:2]); else passes++;
    checks++; if (vc_allocatable_o[1] !== 1'b1) $display("FAIL basic_alloc: got %b, required 1", vc_allocatable_o[1]); else passes++;
    check_drained("basic");
  endtask

  task automatic test_long_packet();
    int sent;
    int rcvd;
    logic do_wr, do_rd;
    logic [FLIT_W-1:0] f;
    sent = 1;
    rcvd = 0;
    write_flit(mk(H, 1'b0, 2'd1, 2'd1, 16'h0100), 1'b1);
    step();
    grant(0, 1'b1);
    for (int cyc = 0; cyc < 400 && rcvd < 16; cyc++) begin
      checks++;
      if (is_full_o[0] && on_off_o[0]) $display("FAIL long_full_on: full=%b on_off=%b, required not both 1", is_full_o[0], on_off_o[0]);
      else passes++;
      do_wr = (sent < 16) && on_off_o[0];
      do_rd = (cyc % 3 == 2) && !is_empty_o[0];
      f = (sent == 15) ? mk(T, 1'b0, 2'd0, 2'd0, 16'h0100 + 16'(sent))
                       : mk(B, 1'b0, 2'd0, 2'd0, 16'h0100 + 16'(sent));
      do_cycle(do_wr, f, 1'b1, do_rd, 0, 1'b1);
      if (do_wr) sent++;
      if (do_rd) rcvd++;
    end
    checks++;
    if (sent != 16 || rcvd != 16) $display("FAIL long_budget: sent %0d read %0d, required 16/16", sent, rcvd);
    else passes++;
    check_drained("long");
  endtask

  task automatic test_framing_heads();
    write_flit(mk(H, 1'b0, 2'd2, 2'd3, 16'hB001), 1'b1);
    write_flit(mk(H, 1'b0, 2'd2, 2'd3, 16'hB002), 1'b0);
    write_flit(mk(H, 1'b0, 2'd2, 2'd3, 16'hB003), 1'b0);
    write_flit(mk(B, 1'b0, 2'd0, 2'd0, 16'hB004), 1'b1);
    write_flit(mk(T, 1'b0, 2'd0, 2'd0, 16'hB005), 1'b1);
    checks++; if (drop_cnt_o !== 8'd2) $display("FAIL heads_drop: got %0d, required 2", drop_cnt_o); else passes++;
    checks++; if (out_port_o[2:0] !== P_S) $display("FAIL heads_port: got %0d, required %0d", out_port_o[2:0], P_S); else passes++;
    grant(0, 1'b1);
    for (int i = 0; i < 3; i++) read_vc(0, 1'b1);
    check_drained("heads");
  endtask

  task automatic test_full_fifo();
    write_flit(mk(H, 1'b0, 2'd2, 2'd2, 16'hC000), 1'b1);
    for (int i = 1; i < 8; i++) write_flit(mk(B, 1'b0, 2'd0, 2'd0, 16'hC000 + 16'(i)), 1'b1);
    checks++; if (is_full_o[0] !== 1'b1) $display("FAIL full_flag: got %b, required 1", is_full_o[0]); else passes++;
    checks++; if (on_off_o[0] !== 1'b0) $display("FAIL full_on_off: got %b, required 0", on_off_o[0]); else passes++;
    write_flit(mk(B, 1'b0, 2'd0, 2'd0, 16'hC0FF), 1'b0);
    checks++; if (drop_cnt_o !== exp_drops) $display("FAIL full_drop: got %0d, required %0d", drop_cnt_o, exp_drops); else passes++;
    grant(0, 1'b0);
    do_cycle(1'b1, mk(B, 1'b0, 2'd0, 2'd0, 16'hC008), 1'b1, 1'b1, 0, 1'b1);
    checks++; if (is_full_o[0] !== 1'b1) $display("FAIL full_rw: got %b, required 1", is_full_o[0]); else passes++;
    do_cycle(1'b1, mk(T, 1'b0, 2'd0, 2'd0, 16'hC009), 1'b1, 1'b1, 0, 1'b1);
    for (int i = 0; i < 8; i++) read_vc(0, 1'b1);
    checks++; if (is_empty_o[0] !== 1'b1) $display("FAIL full_empty_end: got %b, required 1", is_empty_o[0]); else passes++;
    check_drained("full");
  endtask

  task automatic test_stray_body();
    write_flit(mk(B, 1'b0, 2'd0, 2'd0, 16'hD001), 1'b0);
    checks++; if (is_empty_o[0] !== 1'b1) $display("FAIL stray_body_empty: got %b, required 1", is_empty_o[0]); else passes++;
    write_flit(mk(T, 1'b0, 2'd0, 2'd0, 16'hD002), 1'b0);
    checks++; if (is_empty_o[0] !== 1'b1) $display("FAIL stray_tail_empty: got %b, required 1", is_empty_o[0]); else passes++;
    check_drained("stray");
  endtask

  task automatic test_ignored_read();
    read_vc(0, 1'b0);
    checks++; if (valid_flit_o !== 1'b0) $display("FAIL ign_idle_valid: got %b, required 0", valid_flit_o); else passes++;
    write_flit(mk(HT, 1'b1, 2'd2, 2'd1, 16'hE001), 1'b1);
    step();
    read_vc(1, 1'b0);
    checks++; if (valid_flit_o !== 1'b0) $display("FAIL ign_va_valid: got %b, required 0", valid_flit_o); else passes++;
    checks++; if (is_empty_o[1] !== 1'b0) $display("FAIL ign_va_kept: got %b, required 0", is_empty_o[1]); else passes++;
    checks++; if (out_port_o[5:3] !== P_N) $display("FAIL ign_port: got %0d, required %0d", out_port_o[5:3], P_N); else passes++;
    grant(1, 1'b1);
    read_vc(1, 1'b1);
    check_drained("ignored");
  endtask

  task automatic test_interleaved();
    write_flit(mk(H, 1'b0, 2'd1, 2'd2, 16'h0F00), 1'b1);
    write_flit(mk(H, 1'b1, 2'd2, 2'd3, 16'h1F00), 1'b1);
    write_flit(mk(B, 1'b0, 2'd0, 2'd0, 16'h0F01), 1'b1);
    write_flit(mk(B, 1'b1, 2'd0, 2'd0, 16'h1F01), 1'b1);
    write_flit(mk(B, 1'b0, 2'd0, 2'd0, 16'h0F02), 1'b1);
    write_flit(mk(B, 1'b1, 2'd0, 2'd0, 16'h1F02), 1'b1);
    write_flit(mk(T, 1'b0, 2'd0, 2'd0, 16'h0F03), 1'b1);
    write_flit(mk(B, 1'b1, 2'd0, 2'd0, 16'h1F03), 1'b1);
    write_flit(mk(T, 1'b1, 2'd0, 2'd0, 16'h1F04), 1'b1);
    checks++; if (out_port_o[2:0] !== P_W) $display("FAIL inter_port0: got %0d, required %0d", out_port_o[2:0], P_W); else passes++;
    checks++; if (out_port_o[5:3] !== P_S) $display("FAIL inter_port1: got %0d, required %0d", out_port_o[5:3], P_S); else passes++;
    grant(0, 1'b1);
    step();
    grant(1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      read_vc(0, 1'b1);
      read_vc(1, 1'b1);
    end
    read_vc(1, 1'b1);
    check_drained("inter");
  endtask

  task automatic test_reset_mid_packet();
    write_flit(mk(H, 1'b0, 2'd3, 2'd3, 16'h5001), 1'b1);
    write_flit(mk(B, 1'b0, 2'd0, 2'd0, 16'h5002), 1'b1);
    write_flit(mk(B, 1'b0, 2'd0, 2'd0, 16'h5003), 1'b1);
    write_flit(mk(B, 1'b1, 2'd0, 2'd0, 16'h5004), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (is_empty_o !== 2'b11) $display("FAIL mid_rst_empty: got %b, required 11", is_empty_o); else passes++;
    checks++; if (vc_request_o !== 2'b00) $display("FAIL mid_rst_req: got %b, required 00", vc_request_o); else passes++;
    checks++; if (on_off_o !== 2'b11) $display("FAIL mid_rst_on_off: got %b, required 11", on_off_o); else passes++;
    checks++; if (drop_cnt_o !== 8'd0) $display("FAIL mid_rst_drop: got %0d, required 0", drop_cnt_o); else passes++;
    checks++; if (out_port_o !== {P_L, P_L}) $display("FAIL mid_rst_port: got %h, required 0", out_port_o); else passes++;
    checks++; if (vc_allocatable_o !== 2'b11) $display("FAIL mid_rst_alloc: got %b, required 11", vc_allocatable_o); else passes++;
    mq0.delete();
    mq1.delete();
    exp_q.delete();
    exp_drops = '0;
    step();
    rst_n = 1'b1;
    step();
    write_flit(mk(HT, 1'b1, 2'd2, 2'd2, 16'h6001), 1'b1);
    step();
    checks++; if (vc_request_o[1] !== 1'b1) $display("FAIL mid_ht_req: got %b, required 1", vc_request_o[1]); else passes++;
    checks++; if (out_port_o[5:3] !== P_L) $display("FAIL mid_ht_port: got %0d, required %0d", out_port_o[5:3], P_L); else passes++;
    grant(1, 1'b0);
    read_vc(1, 1'b1);
    step();
    checks++; if (vc_allocatable_o[1] !== 1'b1) $display("FAIL mid_ht_alloc: got %b, required 1", vc_allocatable_o[1]); else passes++;
    check_drained("mid_rst");
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_long_packet();
    test_framing_heads();
    test_full_fifo();
    test_stray_body();
    test_ignored_read();
    test_interleaved();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/vc_input_unit.md
# vc_input_unit

Parametrised next-generation router input unit: per-VC flit buffering, per-VC packet state machine, XY route computation, VC-ID rewrite, and on/off backpressure with a configurable threshold. Sits between an upstream link and the VC/switch allocators of one router port. New over the previous input port: arbitrary VC count, registered output with valid, tunable on/off threshold, explicit write-side packet-framing checks, and a saturating drop counter.

## Interface
- VC_NUM, 2: virtual channels; VC_SIZE = $clog2(VC_NUM), minimum 1
- BUFFER_SIZE, 8: flits per VC FIFO, power of two, ≥ 2
- ON_OFF_THRESHOLD, 2: free-slot count at or below which on_off_o[v] drops
- X_CURRENT, MESH_SIZE_X/2: router X coordinate
- Y_CURRENT, MESH_SIZE_Y/2: router Y coordinate
- DROP_CNT_W, 8: drop counter width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- data_i  in  flit_t  incoming flit; vc_id selects the VC
- valid_flit_i  in  1  data_i valid this cycle
- vc_new_i  in  VC_NUM×VC_SIZE  downstream VC granted per VC
- vc_valid_i  in  VC_NUM  VA grant strobe per VC
- vc_sel_i  in  VC_SIZE  VC chosen by switch allocation
- valid_sel_i  in  1  read strobe for vc_sel_i
- flit_o  out  flit_t  registered output flit, vc_id rewritten
- valid_flit_o  out  1  flit_o valid
- on_off_o  out  VC_NUM  1 = upstream may send on VC
- vc_request_o  out  VC_NUM  VA request per VC
- out_port_o  out  VC_NUM×port_t  computed output port per VC
- vc_allocatable_o  out  VC_NUM  VC idle and buffer empty
- is_full_o  out  VC_NUM  FIFO full
- is_empty_o  out  VC_NUM  FIFO empty
- drop_cnt_o  out  DROP_CNT_W  saturating count of discarded flits

## Operation
- Write side, per VC flag in_pkt: HEAD or HEADTAIL accepted only when in_pkt=0; HEAD sets in_pkt. BODY accepted only when in_pkt=1. TAIL accepted when in_pkt=1, clears it. HEADTAIL leaves in_pkt=0.
- Discarded: framing violations (stray BODY/TAIL, repeated HEAD/HEADTAIL inside a packet) and any write to a full FIFO. Each discard increments drop_cnt_o by 1, saturating at all-ones; FIFO and in_pkt unchanged.
- Read-side FSM per VC: IDLE, VA, ACTIVE.
  - IDLE: FIFO non-empty and front is HEAD/HEADTAIL → compute XY route, latch out_port_o[v], go VA. Front BODY/TAIL in IDLE cannot occur (write filter).
  - VA: vc_request_o[v]=1. On vc_valid_i[v] latch vc_new_i[v], go ACTIVE; vc_request_o[v] drops same edge.
  - ACTIVE: valid_sel_i with vc_sel_i=v pops front flit. Popping TAIL/HEADTAIL → IDLE.
- XY routing: x_dest>X_CURRENT EAST; x_dest<X_CURRENT WEST; else y_dest>Y_CURRENT SOUTH; y_dest<Y_CURRENT NORTH; else LOCAL.
- flit_o = popped flit with vc_id replaced by latched new VC.
- Read strobe on a VC not ACTIVE or empty: ignored, valid_flit_o=0, no state change.
- on_off_o[v] = (BUFFER_SIZE − count[v]) > ON_OFF_THRESHOLD, registered.
- vc_allocatable_o[v] = IDLE and empty.

## Timing
- Reset (async, immediate): FIFOs empty, in_pkt=0, all FSMs IDLE, flit_o=0, valid_flit_o=0, vc_request_o=0, out_port_o=LOCAL, on_off_o all 1, vc_allocatable_o all 1, is_empty_o all 1, is_full_o 0, drop_cnt_o 0. Reset mid-packet discards everything.
- Write at edge t: is_empty_o/is_full_o/on_off_o reflect it after t.
- HEAD written at t reaches empty VC front: IDLE→VA at t+1, vc_request_o high after t+1.
- Grant at edge t: ACTIVE after t; earliest read strobe sampled at t+1.
- Read strobe sampled at t: flit_o/valid_flit_o valid after t for one cycle; FIFO pointer advances at t.
- Simultaneous write and read on same VC: both performed, count unchanged; write to full FIFO with concurrent pop of that VC accepted.
- Pointers wrap modulo BUFFER_SIZE; count width $clog2(BUFFER_SIZE)+1.
- Tail popped at t while next HEAD already at front: IDLE after t, VA after t+1.

## Test plan
- VC1 4-flit packet (HEAD x=Xc+1, BODY, BODY, TAIL), grant vc_new=0, 4 reads → out_port EAST, flit_o sequence identical with vc_id=0, vc_request high exactly from HEAD+1 to grant, FSM returns IDLE, vc_allocatable_o[1]=1.
- BUFFER_SIZE=8, 16-flit packet, reads paced by on_off_o → no drops, is_full_o never with on_off_o=1, all 16 flits in order.
- HEAD, HEAD, HEAD, BODY, TAIL on VC0 → 3 flits stored, drop_cnt_o=2.
- BODY then TAIL on empty VC0 with no HEAD → is_empty_o[0] stays 1, drop_cnt_o=2.
- Two VCs interleaved (4 and 5 flits), grants at different cycles, alternating reads → per-VC ordering preserved, no cross-VC mixing.
- rst_n low mid-packet with 3 flits buffered → all outputs at reset values immediately; subsequent HEADTAIL to LOCAL routes and reads correctly.
